// File: rtl/mat_pkg.sv
// Shared types and constants for the matrix sequencing controller.
package mat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_B  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DRAIN_C = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [31:0] ADDR_CTRL   = 32'h0;
    localparam logic [31:0] ADDR_STATUS = 32'h4;
    localparam logic [31:0] ADDR_DIM    = 32'h8;
    localparam logic [31:0] ADDR_CYCLES = 32'hC;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] status_word(
        input logic   busy,
        input logic   done,
        input logic   err,
        input state_t st
    );
        return {25'd0, st, 1'b0, err, done, busy};
    endfunction

endpackage

// File: rtl/mat_ctrl_regs.sv
// AXI-lite slave register front end for mat_seq_ctrl.
module mat_ctrl_regs
    import mat_pkg::*;
#(
    parameter int N = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    input  logic        busy,
    input  logic        done,
    input  logic        err,
    input  state_t      state,
    input  logic [31:0] cycles,
    output logic        start_cmd,
    output logic        abort_cmd
);

    logic        aw_rdy;
    logic        wr_hs;
    logic        rd_hs;
    logic        wr_ctrl;
    logic [1:0]  wr_resp;
    logic [1:0]  rd_resp;
    logic [31:0] rd_val;
    logic        unused_wdata;

    assign awready      = aw_rdy;
    assign wready       = aw_rdy;
    assign wr_hs        = aw_rdy && awvalid && wvalid;
    assign rd_hs        = arready && arvalid;
    assign unused_wdata = ^wdata[31:2];

    always_comb begin
        wr_ctrl = 1'b0;
        wr_resp = RESP_SLVERR;
        if (awaddr == ADDR_CTRL) begin
            wr_ctrl = 1'b1;
            wr_resp = RESP_OKAY;
        end
    end

    always_comb begin
        rd_resp = RESP_OKAY;
        rd_val  = '0;
        unique case (1'b1)
            (araddr == ADDR_CTRL):   rd_val = '0;
            (araddr == ADDR_STATUS): rd_val = status_word(busy, done, err, state);
            (araddr == ADDR_DIM):    rd_val = 32'(N);
            (araddr == ADDR_CYCLES): rd_val = cycles;
            default:                 rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_rdy    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            rresp     <= RESP_OKAY;
            start_cmd <= 1'b0;
            abort_cmd <= 1'b0;
        end else begin
            start_cmd <= 1'b0;
            abort_cmd <= 1'b0;
            // Ready is a one-cycle strobe; an open response blocks new writes.
            aw_rdy  <= !aw_rdy && !bvalid && awvalid && wvalid;
            arready <= !arready && !rvalid && arvalid;
            if (wr_hs) begin
                bvalid <= 1'b1;
                bresp  <= wr_resp;
                if (wr_ctrl) begin
                    start_cmd <= wdata[0];
                    abort_cmd <= wdata[1];
                end
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
            if (rd_hs) begin
                rvalid <= 1'b1;
                rdata  <= rd_val;
                rresp  <= rd_resp;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mat_seq_ctrl.sv
// Matrix load/compute/drain sequencer with AXI-lite control.
// Optional busy-cycle counter enabled by MAT_SEQ_PERF_CNT_EN.
module mat_seq_ctrl
    import mat_pkg::*;
#(
    parameter  int N  = 4,
    localparam int NN = N * N,
    localparam int IW = (NN > 1) ? $clog2(NN) : 1
) (
    input  logic          ACLK,
    input  logic          ARST,
    input  logic          awvalid,
    output logic          awready,
    input  logic [31:0]   awaddr,
    input  logic          wvalid,
    output logic          wready,
    input  logic [31:0]   wdata,
    output logic          bvalid,
    input  logic          bready,
    output logic [1:0]    bresp,
    input  logic          arvalid,
    output logic          arready,
    input  logic [31:0]   araddr,
    output logic          rvalid,
    input  logic          rready,
    output logic [31:0]   rdata,
    output logic [1:0]    rresp,
    input  logic          a_tvalid,
    output logic          a_tready,
    input  logic          a_tlast,
    input  logic          b_tvalid,
    output logic          b_tready,
    input  logic          b_tlast,
    output logic          c_tvalid,
    input  logic          c_tready,
    output logic          c_tlast,
    output logic [IW-1:0] elem_idx,
    output logic          eng_start,
    input  logic          eng_done
);

    localparam logic [IW-1:0] LAST = IW'(NN - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);

    state_t      state;
    logic        done;
    logic        err;
    logic        busy;
    logic        start_cmd;
    logic        abort_cmd;
    logic        start_go;
    logic        is_last;
    logic [31:0] cycles;

    assign busy     = (state != ST_IDLE) && (state != ST_DONE);
    assign start_go = start_cmd && !abort_cmd && (state == ST_IDLE);
    assign is_last  = (elem_idx == LAST);

    mat_ctrl_regs #(.N(N)) u_regs (
        .clk       (ACLK),
        .rst       (ARST),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .bvalid    (bvalid),
        .bready    (bready),
        .bresp     (bresp),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state     (state),
        .cycles    (cycles),
        .start_cmd (start_cmd),
        .abort_cmd (abort_cmd)
    );

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state     <= ST_IDLE;
            elem_idx  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            a_tready  <= 1'b0;
            b_tready  <= 1'b0;
            c_tvalid  <= 1'b0;
            c_tlast   <= 1'b0;
            eng_start <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            if (abort_cmd) begin
                state    <= ST_IDLE;
                elem_idx <= '0;
                a_tready <= 1'b0;
                b_tready <= 1'b0;
                c_tvalid <= 1'b0;
                c_tlast  <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start_cmd) begin
                            state    <= ST_LOAD_A;
                            done     <= 1'b0;
                            err      <= 1'b0;
                            elem_idx <= '0;
                            a_tready <= 1'b1;
                        end
                    end
                    ST_LOAD_A: begin
                        if (a_tvalid && a_tready) begin
                            // Misplaced or missing tlast is flagged, not fatal.
                            if (a_tlast != is_last) err <= 1'b1;
                            if (is_last) begin
                                elem_idx <= '0;
                                state    <= ST_LOAD_B;
                                a_tready <= 1'b0;
                                b_tready <= 1'b1;
                            end else begin
                                elem_idx <= elem_idx + ONE;
                            end
                        end
                    end
                    ST_LOAD_B: begin
                        if (b_tvalid && b_tready) begin
                            if (b_tlast != is_last) err <= 1'b1;
                            if (is_last) begin
                                elem_idx  <= '0;
                                state     <= ST_COMPUTE;
                                b_tready  <= 1'b0;
                                eng_start <= 1'b1;
                            end else begin
                                elem_idx <= elem_idx + ONE;
                            end
                        end
                    end
                    ST_COMPUTE: begin
                        if (eng_done) begin
                            state    <= ST_DRAIN_C;
                            c_tvalid <= 1'b1;
                            c_tlast  <= is_last;
                        end
                    end
                    ST_DRAIN_C: begin
                        if (c_tready) begin
                            if (is_last) begin
                                state    <= ST_DONE;
                                done     <= 1'b1;
                                elem_idx <= '0;
                                c_tvalid <= 1'b0;
                                c_tlast  <= 1'b0;
                            end else begin
                                elem_idx <= elem_idx + ONE;
                                c_tlast  <= ((elem_idx + ONE) == LAST);
                            end
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef MAT_SEQ_PERF_CNT_EN
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            cycles <= '0;
        end else if (start_go) begin
            cycles <= '0;
        end else if (busy && (cycles != 32'hFFFF_FFFF)) begin
            cycles <= cycles + 32'd1;
        end
    end
`else
    assign cycles = '0;
`endif

endmodule

// File: tb/tb_mat_seq_ctrl.sv
// Self-checking bench for mat_seq_ctrl (N=4).
module tb_mat_seq_ctrl;

    localparam int N  = 4;
    localparam int NN = 16;
    localparam int IW = 4;

    logic          ACLK = 0;
    logic          ARST;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0]   awaddr, wdata, araddr, rdata;
    logic [1:0]    bresp, rresp;
    logic          arvalid, arready, rvalid, rready;
    logic          a_tvalid, a_tready, a_tlast;
    logic          b_tvalid, b_tready, b_tlast;
    logic          c_tvalid, c_tready, c_tlast;
    logic [IW-1:0] elem_idx;
    logic          eng_start, eng_done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int estart_cnt = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] rd;
    } vec_t;

    vec_t vt[13];

    mat_seq_ctrl #(.N(N)) dut (
        .ACLK(ACLK), .ARST(ARST),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .a_tvalid(a_tvalid), .a_tready(a_tready), .a_tlast(a_tlast),
        .b_tvalid(b_tvalid), .b_tready(b_tready), .b_tlast(b_tlast),
        .c_tvalid(c_tvalid), .c_tready(c_tready), .c_tlast(c_tlast),
        .elem_idx(elem_idx), .eng_start(eng_start), .eng_done(eng_done)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;
    always @(negedge ACLK) if (eng_start) estart_cnt++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             output logic [1:0] resp);
        int g;
        resp = 2'b11;
        awaddr = addr; wdata = data; awvalid = 1; wvalid = 1;
        g = 0;
        while (!(awready && wready) && g < 50) begin @(negedge ACLK); g++; end
        if (g >= 50) begin awvalid = 0; wvalid = 0; timeout("aw"); return; end
        @(negedge ACLK);
        awvalid = 0; wvalid = 0;
        g = 0;
        while (!bvalid && g < 50) begin @(negedge ACLK); g++; end
        if (g >= 50) begin timeout("b"); return; end
        resp = bresp; bready = 1;
        @(negedge ACLK);
        bready = 0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int g;
        data = '1; resp = 2'b11;
        araddr = addr; arvalid = 1;
        g = 0;
        while (!arready && g < 50) begin @(negedge ACLK); g++; end
        if (g >= 50) begin arvalid = 0; timeout("ar"); return; end
        @(negedge ACLK);
        arvalid = 0;
        g = 0;
        while (!rvalid && g < 50) begin @(negedge ACLK); g++; end
        if (g >= 50) begin timeout("r"); return; end
        data = rdata; resp = rresp; rready = 1;
        @(negedge ACLK);
        rready = 0;
    endtask

    task automatic load(input bit sel_b, input logic [NN-1:0] tl,
                        output int e0, output bit bad);
        int k, g;
        bit v, rdy, other, seen;
        k = 0; g = 0; seen = 0; bad = 0; e0 = 0;
        while (k < NN && g < 3000) begin
            v = ($urandom_range(0, 3) != 0);
            rdy = sel_b ? b_tready : a_tready;
            other = sel_b ? a_tready : b_tready;
            if (rdy && !seen) begin seen = 1; e0 = cyc; end
            if (sel_b) begin b_tvalid = v; b_tlast = tl[k]; end
            else begin a_tvalid = v; a_tlast = tl[k]; end
            if ((rdy && other) || c_tvalid) bad = 1;
            if (v && rdy) begin
                if (elem_idx != k[IW-1:0]) bad = 1;
                k++;
            end
            @(negedge ACLK);
            g++;
        end
        a_tvalid = 0; b_tvalid = 0; a_tlast = 0; b_tlast = 0;
        if (k < NN) timeout(sel_b ? "load_b" : "load_a");
    endtask

    task automatic run_job(input string tag, input logic [NN-1:0] tla,
                           input logic [NN-1:0] tlb, input int dly,
                           input int stall_at, input int abort_at);
        logic [1:0]    r;
        logic [31:0]   d;
        logic [NN-1:0] ideal;
        bit            exp_err, bad, cbad, sbad, rdy, stalled, aborted;
        int            e0, e1, dummy, k, g, st0;
        ideal = '0;
        ideal[NN-1] = 1'b1;
        exp_err = (tla != ideal) || (tlb != ideal);
        st0 = estart_cnt;
        e1 = 0;
        axi_write(32'h0, 32'h1, r);
        chk($sformatf("%s start_bresp", tag), r, 2'b00);
        load(0, tla, e0, bad);
        chk($sformatf("%s load_a", tag), bad, 0);
        load(1, tlb, dummy, bad);
        chk($sformatf("%s load_b", tag), bad, 0);
        g = 0;
        while (!eng_start && g < 50) begin @(negedge ACLK); g++; end
        if (g >= 50) timeout("eng_start");
        cbad = 0;
        for (int i = 0; i < dly; i++) begin
            @(negedge ACLK);
            if (c_tvalid || a_tready || b_tready) cbad = 1;
        end
        chk($sformatf("%s compute_quiet", tag), cbad, 0);
        eng_done = 1;
        @(negedge ACLK);
        eng_done = 0;
        k = 0; g = 0; bad = 0; sbad = 0; stalled = 0; aborted = 0;
        while (k < NN && g < 3000 && !aborted) begin
            if (k == abort_at) begin
                c_tready = 0;
                axi_write(32'h0, 32'h2, r);
                chk($sformatf("%s abort_bresp", tag), r, 2'b00);
                @(negedge ACLK);
                chk($sformatf("%s abort_c_tvalid", tag), c_tvalid, 0);
                chk($sformatf("%s abort_idx", tag), elem_idx, 0);
                chk($sformatf("%s abort_readies", tag), {a_tready, b_tready}, 0);
                axi_read(32'h4, d, r);
                chk($sformatf("%s abort_status", tag), d, exp_err ? 32'h4 : 32'h0);
                aborted = 1;
            end else begin
                if (k == stall_at && !stalled) begin
                    c_tready = 0;
                    stalled = 1;
                    repeat (10) begin
                        @(negedge ACLK);
                        if (!c_tvalid || elem_idx != k[IW-1:0]) sbad = 1;
                    end
                end
                if (!c_tvalid) bad = 1;
                rdy = ($urandom_range(0, 3) != 0);
                c_tready = rdy;
                if (c_tvalid && rdy) begin
                    if (elem_idx != k[IW-1:0] || c_tlast != (k == NN - 1)) bad = 1;
                    if (k == NN - 1) e1 = cyc + 1;
                    k++;
                end
                @(negedge ACLK);
                g++;
            end
        end
        c_tready = 0;
        chk($sformatf("%s eng_start_pulses", tag), estart_cnt - st0, 1);
        if (!aborted) begin
            if (k < NN) timeout("drain");
            chk($sformatf("%s drain_beats", tag), bad, 0);
            if (stall_at >= 0) chk($sformatf("%s stall_hold", tag), sbad, 0);
            chk($sformatf("%s c_tvalid_end", tag), c_tvalid, 0);
            axi_read(32'h4, d, r);
            chk($sformatf("%s status", tag), d, exp_err ? 32'h6 : 32'h2);
            axi_read(32'hC, d, r);
`ifdef MAT_SEQ_PERF_CNT_EN
            chk($sformatf("%s cycles", tag), d, 32'(e1 - e0));
`else
            chk($sformatf("%s cycles", tag), d, 32'(e1 - e1));
`endif
        end
    endtask

    initial begin
        logic [1:0]    r;
        logic [31:0]   d;
        logic [NN-1:0] ideal, ta, tb;
        int            e0, st, dl;
        bit            bad;

        ARST = 1;
        awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; bready = 0;
        arvalid = 0; araddr = 0; rready = 0;
        a_tvalid = 0; a_tlast = 0; b_tvalid = 0; b_tlast = 0;
        c_tready = 0; eng_done = 0;
        ideal = '0;
        ideal[NN-1] = 1'b1;

        vt[0]  = '{0, 32'h4,  32'h0,  2'b00, 32'h0};
        vt[1]  = '{0, 32'h8,  32'h0,  2'b00, 32'h4};
        vt[2]  = '{0, 32'hC,  32'h0,  2'b00, 32'h0};
        vt[3]  = '{0, 32'h0,  32'h0,  2'b00, 32'h0};
        vt[4]  = '{0, 32'h10, 32'h0,  2'b10, 32'h0};
        vt[5]  = '{1, 32'h4,  32'hFF, 2'b10, 32'h0};
        vt[6]  = '{0, 32'h4,  32'h0,  2'b00, 32'h0};
        vt[7]  = '{1, 32'h8,  32'h1,  2'b10, 32'h0};
        vt[8]  = '{1, 32'hC,  32'h1,  2'b10, 32'h0};
        vt[9]  = '{1, 32'h20, 32'h1,  2'b10, 32'h0};
        vt[10] = '{1, 32'h0,  32'h0,  2'b00, 32'h0};
        vt[11] = '{0, 32'h6,  32'h0,  2'b10, 32'h0};
        vt[12] = '{0, 32'h4,  32'h0,  2'b00, 32'h0};

        repeat (3) @(negedge ACLK);
        chk("reset_outputs",
            {awready, wready, bvalid, arready, rvalid, a_tready, b_tready,
             c_tvalid, c_tlast, eng_start, bresp, rresp, rdata, elem_idx}, 0);
        ARST = 0;
        @(negedge ACLK);

        for (int i = 0; i < 13; i++) begin
            if (vt[i].wr) begin
                axi_write(vt[i].addr, vt[i].data, r);
                chk($sformatf("reg_vec%0d bresp", i), r, vt[i].resp);
            end else begin
                axi_read(vt[i].addr, d, r);
                chk($sformatf("reg_vec%0d rresp", i), r, vt[i].resp);
                chk($sformatf("reg_vec%0d rdata", i), d, vt[i].rd);
            end
        end

        run_job("basic", ideal, ideal, 5, -1, -1);

        axi_read(32'h10, d, r);
        chk("bad_read rresp", r, 2'b10);
        axi_write(32'h4, 32'h3, r);
        chk("ro_write bresp", r, 2'b10);
        axi_read(32'h4, d, r);
        chk("ro_write status", d, 32'h2);

        ta = ideal;
        ta[7] = 1'b1;
        run_job("early_tlast", ta, ideal, 3, -1, -1);
        run_job("stall", ideal, ideal, 2, 6, -1);
        run_job("abort", ideal, ideal, 4, -1, 5);
        run_job("after_abort", ideal, ideal, 0, -1, -1);

        for (int j = 0; j < 6; j++) begin
            ta = ideal;
            tb = ideal;
            if ($urandom_range(0, 2) == 0) ta[$urandom_range(0, NN - 1)] ^= 1'b1;
            if ($urandom_range(0, 2) == 0) tb[$urandom_range(0, NN - 1)] ^= 1'b1;
            dl = $urandom_range(0, 8);
            st = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, NN - 1);
            run_job($sformatf("rand%0d", j), ta, tb, dl, st, -1);
        end

        axi_write(32'h0, 32'h1, r);
        a_tvalid = 1; a_tlast = 0;
        repeat (3) @(negedge ACLK);
        a_tvalid = 0;
        chk("rst1 idx_before", elem_idx, 3);
        axi_write(32'h0, 32'h1, r);
        chk("busy_start bresp", r, 2'b00);
        chk("busy_start idx", elem_idx, 3);
        chk("busy_start a_tready", a_tready, 1);
        #2 ARST = 1;
        #1 chk("rst1 async", {a_tready, elem_idx}, 0);
        @(negedge ACLK);
        ARST = 0;
        @(negedge ACLK);

        axi_write(32'h0, 32'h1, r);
        load(0, ideal, e0, bad);
        load(1, ideal, e0, bad);
        chk("rst2 eng_start_pre", eng_start, 1);
        #2 ARST = 1;
        #1 chk("rst2 async_outputs",
               {awready, wready, bvalid, arready, rvalid, a_tready, b_tready,
                c_tvalid, c_tlast, eng_start, bresp, rresp, rdata, elem_idx}, 0);
        @(negedge ACLK);
        ARST = 0;
        @(negedge ACLK);
        axi_read(32'h4, d, r);
        chk("rst2 status", d, 32'h0);
        axi_read(32'hC, d, r);
        chk("rst2 cycles", d, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mat_seq_ctrl.md
MAT_SEQ_CTRL -- requirements
Module: mat_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, matrix dimension; each matrix is N*N 32-bit elements.
REQ-002 ACLK  in  1  single clock; all logic on rising edge.
REQ-003 ARST  in  1  reset, asynchronous, active-high.
REQ-004 awvalid  in  1  AXI-lite write-address valid.
REQ-005 awready  out  1  write-address ready.
REQ-006 awaddr  in  32  write address; bits [3:2] decoded.
REQ-007 wvalid  in  1  write-data valid.
REQ-008 wready  out  1  write-data ready.
REQ-009 wdata  in  32  write data.
REQ-010 bvalid  out  1  write-response valid.
REQ-011 bready  in  1  write-response ready.
REQ-012 bresp  out  2  OKAY=0, SLVERR=2.
REQ-013 arvalid  in  1  read-address valid.
REQ-014 arready  out  1  read-address ready.
REQ-015 araddr  in  32  read address; bits [3:2] decoded.
REQ-016 rvalid  out  1  read-data valid.
REQ-017 rready  in  1  read-data ready.
REQ-018 rdata  out  32  read data.
REQ-019 rresp  out  2  OKAY=0, SLVERR=2.
REQ-020 a_tvalid  in  1  A stream valid.
REQ-021 a_tready  out  1  A stream ready.
REQ-022 a_tlast  in  1  A stream last.
REQ-023 b_tvalid  in  1  B stream valid.
REQ-024 b_tready  out  1  B stream ready.
REQ-025 b_tlast  in  1  B stream last.
REQ-026 c_tvalid  out  1  C stream valid; data is supplied by the engine, indexed by elem_idx.
REQ-027 c_tready  in  1  C stream ready.
REQ-028 c_tlast  out  1  C stream last.
REQ-029 elem_idx  out  $clog2(N*N)  current element index for A/B load and C drain.
REQ-030 eng_start  out  1  one-cycle compute start pulse.
REQ-031 eng_done  in  1  engine compute complete (level or pulse).

Function
REQ-032 Register map SHALL be: 0x0 CTRL (W: bit0 START, bit1 ABORT, both self-clearing; reads 0), 0x4 STATUS (RO: bit0 BUSY, bit1 DONE sticky, bit2 ERR sticky, bits[6:4] state), 0x8 DIM (RO: N), 0xC CYCLES (RO). Any other address → SLVERR. Writes to RO registers → SLVERR with no effect.
REQ-033 AXI-lite write SHALL accept AW and W only when both are valid (awready=wready=1 for that single cycle). bvalid asserts the next cycle and holds until bready. No new write is accepted while bvalid=1.
REQ-034 AXI-lite read SHALL assert arready for one cycle. rvalid asserts the next cycle with rdata and holds until rready.
REQ-035 FSM states SHALL be IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN_C, DONE.
  - IDLE→LOAD_A on START write; clears DONE/ERR and elem_idx.
  - START while BUSY is ignored (OKAY response).
REQ-036 a_tready=1 only in LOAD_A and b_tready=1 only in LOAD_B. Each handshake increments elem_idx. After N*N beats, elem_idx wraps to 0 and the FSM advances.
  - tlast asserted on a non-final beat sets ERR; loading continues.
  - Missing tlast on the final beat sets ERR; loading continues.
REQ-037 eng_start SHALL pulse exactly one cycle on LOAD_B→COMPUTE. COMPUTE→DRAIN_C on eng_done=1.
REQ-038 c_tvalid=1 throughout DRAIN_C. elem_idx advances on each c_tvalid&&c_tready. c_tlast=1 when elem_idx=N*N-1. The final handshake → DONE.
REQ-039 DONE sets the STATUS.DONE sticky bit and returns to IDLE the next cycle. BUSY=1 in all states except IDLE and DONE.
REQ-040 ABORT in any state SHALL force IDLE, clear elem_idx and drop all readies/valids the next cycle. An in-flight AXI-lite response completes normally.
REQ-041 When a CTRL write and a stream handshake occur in the same cycle, ABORT takes priority and START is ignored unless in IDLE.

Reset
REQ-042 While ARST=1, the following SHALL be 0:
  - state IDLE, elem_idx, all registers;
  - awready, wready, bvalid, arready, rvalid, a_tready, b_tready, c_tvalid, c_tlast, eng_start;
  - bresp, rresp, rdata.
  Reset mid-transaction discards the transaction.

Configuration
REQ-043 With MAT_SEQ_PERF_CNT_EN defined, CYCLES SHALL count ACLK cycles while BUSY=1, clear on START, and saturate at 0xFFFFFFFF.
  - Without it, CYCLES reads 0 with OKAY and no counter is synthesized.

Structure
REQ-044 Shared package mat_pkg SHALL hold:
  - the state enum;
  - register offsets;
  - the RESP_OKAY/RESP_SLVERR constants.
  The AXI-lite slave front end SHALL be sub-module mat_ctrl_regs; the FSM and counters stay in mat_seq_ctrl.

Verification
REQ-045 N=4; write START; drive 16 A beats (tlast on 16th) and 16 B beats; eng_done 5 cycles after eng_start → exactly one eng_start pulse; 16 C beats with c_tlast on beat 16; STATUS reads 0x2.
REQ-046 A-stream tlast on beat 8 of 16 → STATUS.ERR=1 after completion; DONE still set.
REQ-047 Assert ABORT during DRAIN_C at beat 5 → c_tvalid=0 the next cycle; STATUS state=IDLE, BUSY=0.
REQ-048 Read 0x10, then write 0x4 → rresp=2 and bresp=2; STATUS unchanged.
REQ-049 c_tready held low 10 cycles mid-drain → c_tvalid stays 1 and elem_idx holds. With MAT_SEQ_PERF_CNT_EN, CYCLES increases by exactly the BUSY duration.
REQ-050 Assert ARST in COMPUTE → all outputs 0 immediately (asynchronous); after release, STATUS reads 0.
